// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-sequencer state encoding, mult/div latencies
// and the ERET opcode matched by the instruction decoders.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_VECTOR = 2'd2
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    localparam logic [31:0] ERET_OPCODE = 32'h42000018;

    // A source operand collides when it is actually read and names the producer's register.
    function automatic logic reg_match(input logic use_src, input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src & (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Occupancy counter for the multi-cycle mult/div unit: loads the op latency on
// launch, counts down to zero, and reports busy while nonzero.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             is_div_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    // A launch while busy simply reloads; the previous op is abandoned.
    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = is_div_i ? DIV_LD : MULT_LD;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o  = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and interrupt sequencer for the five-stage pipeline: load-use and
// mult/div hazard stalls plus a RUN -> FLUSH -> VECTOR exception entry sequence.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic       isMdD,
    input  logic       loadE,
    input  logic [4:0] wrRegE,
    input  logic       mdStartE,
    input  logic       mdIsDivE,
    input  logic       eretD,
    input  logic       eretE,
    input  logic       irq,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic       intclr,
    output logic       epcWe,
    output logic       pcselExc,
    output logic       mdBusy,
    output state_e     dbg_state_o
);

    state_e           state_q, state_d;
    logic             load_use, md_stall, stall;
    logic [CNT_W-1:0] md_count;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .start_i  (mdStartE),
        .is_div_i (mdIsDivE),
        .busy_o   (mdBusy),
        .count_o  (md_count)
    );

    // $zero is never a real producer, so a load into it cannot create a hazard.
    assign load_use = loadE & (wrRegE != 5'd0) &
                      (reg_match(useRsD, rsD, wrRegE) | reg_match(useRtD, rtD, wrRegE));
    assign md_stall = isMdD & (mdBusy | mdStartE);
    assign stall    = (load_use | md_stall) & (state_q == ST_RUN);

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

    // An eret in D or E defers the interrupt so the return is not torn in half.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (irq & ~eretD & ~eretE) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_VECTOR;
            ST_VECTOR: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign intclr      = (state_q == ST_FLUSH);
    assign epcWe       = (state_q == ST_FLUSH);
    assign pcselExc    = (state_q == ST_VECTOR);
    assign dbg_state_o = state_q;

    logic unused_count;
    assign unused_count = ^md_count;

endmodule
